// File: rtl/cordic_sequencer.sv
// Front-end controller for the iterative 8-bit CORDIC sin/cos engine.
// Arbitrates two requesters round-robin, folds a full-circle angle into the
// engine's first quadrant, sequences init/run/halt and returns sign-corrected
// cos/sin magnitudes over a valid/ready response channel with a timeout guard.
module cordic_sequencer #(
  parameter int unsigned INIT_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 31
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] REQ_VALID,
  input  logic [9:0] REQ_ANGLE0,
  input  logic [9:0] REQ_ANGLE1,
  output logic [1:0] REQ_READY,
  output logic [7:0] ENG_ANGLE,
  output logic       ENG_RESET,
  input  logic [7:0] ENG_COS,
  input  logic [7:0] ENG_SIN,
  input  logic       ENG_HALT,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic       RSP_ID,
  output logic [7:0] RSP_COS,
  output logic       RSP_COS_NEG,
  output logic [7:0] RSP_SIN,
  output logic       RSP_SIN_NEG,
  output logic       RSP_ERR,
  output logic       BUSY
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned MAG_W = 8;
  localparam int unsigned ANG_W = 10;

  // Last INIT counter value before RUN.
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  // Last RUN counter value still waiting for HALT; the error response then
  // occupies the slot that would have been RUN cycle TIMEOUT.
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_last, w_last_nxt;
  logic               r_id, w_id_nxt;
  logic [1:0]         r_q, w_q_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [MAG_W-1:0]   r_eng_angle, w_eng_angle_nxt;
  logic               r_eng_reset, w_eng_reset_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [MAG_W-1:0]   r_rsp_cos, w_rsp_cos_nxt;
  logic               r_rsp_cos_neg, w_rsp_cos_neg_nxt;
  logic [MAG_W-1:0]   r_rsp_sin, w_rsp_sin_nxt;
  logic               r_rsp_sin_neg, w_rsp_sin_neg_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;

  logic               w_any_req;
  logic               w_grant_id;
  logic [1:0]         w_grant_vec;
  logic [ANG_W-1:0]   w_angle;
  logic [MAG_W-1:0]   w_map_cos;
  logic [MAG_W-1:0]   w_map_sin;
  logic               w_map_cos_neg;
  logic               w_map_sin_neg;

  // Round-robin arbitration: contention goes to the requester not granted last.
  always_comb begin
    w_any_req   = |REQ_VALID;
    w_grant_id  = (REQ_VALID == 2'b11) ? ~r_last : REQ_VALID[1];
    w_grant_vec = 2'b00;
    if ((r_state == S_IDLE) && w_any_req) begin
      w_grant_vec = w_grant_id ? 2'b10 : 2'b01;
    end
    w_angle = w_grant_id ? REQ_ANGLE1 : REQ_ANGLE0;
  end

  // Quadrant map of the engine's first-quadrant result onto the full circle.
  always_comb begin
    w_map_cos     = ENG_COS;
    w_map_sin     = ENG_SIN;
    w_map_cos_neg = 1'b0;
    w_map_sin_neg = 1'b0;
    case (r_q)
      2'd0: begin
        w_map_cos     = ENG_COS;
        w_map_sin     = ENG_SIN;
      end
      2'd1: begin
        w_map_cos     = ENG_SIN;
        w_map_cos_neg = 1'b1;
        w_map_sin     = ENG_COS;
      end
      2'd2: begin
        w_map_cos_neg = 1'b1;
        w_map_sin_neg = 1'b1;
      end
      default: begin
        w_map_cos     = ENG_SIN;
        w_map_sin     = ENG_COS;
        w_map_sin_neg = 1'b1;
      end
    endcase
  end

  // Next-state and next-register logic for the job sequencer.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_nxt        = r_last;
    w_id_nxt          = r_id;
    w_q_nxt           = r_q;
    w_cnt_nxt         = r_cnt;
    w_eng_angle_nxt   = r_eng_angle;
    w_eng_reset_nxt   = r_eng_reset;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_cos_nxt     = r_rsp_cos;
    w_rsp_cos_neg_nxt = r_rsp_cos_neg;
    w_rsp_sin_nxt     = r_rsp_sin;
    w_rsp_sin_neg_nxt = r_rsp_sin_neg;
    w_rsp_err_nxt     = r_rsp_err;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt     = S_INIT;
          w_last_nxt      = w_grant_id;
          w_id_nxt        = w_grant_id;
          w_q_nxt         = w_angle[9:8];
          w_eng_angle_nxt = w_angle[7:0];
          w_cnt_nxt       = '0;
          w_eng_reset_nxt = 1'b0;
        end
      end
      S_INIT: begin
        if (r_cnt == INIT_LAST) begin
          w_state_nxt     = S_RUN;
          w_cnt_nxt       = '0;
          w_eng_reset_nxt = 1'b1;
        end else begin
          w_cnt_nxt       = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        // HALT in the first RUN cycle is left over from the previous job.
        if ((r_cnt != '0) && ENG_HALT) begin
          w_state_nxt       = S_RESP;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = 1'b0;
          w_rsp_cos_nxt     = w_map_cos;
          w_rsp_cos_neg_nxt = w_map_cos_neg;
          w_rsp_sin_nxt     = w_map_sin;
          w_rsp_sin_neg_nxt = w_map_sin_neg;
        end else if (r_cnt == RUN_LAST) begin
          w_state_nxt       = S_RESP;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_cos_nxt     = '0;
          w_rsp_cos_neg_nxt = 1'b0;
          w_rsp_sin_nxt     = '0;
          w_rsp_sin_neg_nxt = 1'b0;
        end else begin
          w_cnt_nxt         = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; pointer resets to favour requester 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_id          <= 1'b0;
      r_q           <= 2'd0;
      r_cnt         <= '0;
      r_eng_angle   <= '0;
      r_eng_reset   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_cos     <= '0;
      r_rsp_cos_neg <= 1'b0;
      r_rsp_sin     <= '0;
      r_rsp_sin_neg <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_id          <= w_id_nxt;
      r_q           <= w_q_nxt;
      r_cnt         <= w_cnt_nxt;
      r_eng_angle   <= w_eng_angle_nxt;
      r_eng_reset   <= w_eng_reset_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_cos     <= w_rsp_cos_nxt;
      r_rsp_cos_neg <= w_rsp_cos_neg_nxt;
      r_rsp_sin     <= w_rsp_sin_nxt;
      r_rsp_sin_neg <= w_rsp_sin_neg_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
    end
  end

  // Accept strobe is the arbitration result, forced low while reset is held.
  assign REQ_READY   = w_grant_vec & {2{RESET}};
  assign ENG_ANGLE   = r_eng_angle;
  assign ENG_RESET   = r_eng_reset;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_ID      = r_id;
  assign RSP_COS     = r_rsp_cos;
  assign RSP_COS_NEG = r_rsp_cos_neg;
  assign RSP_SIN     = r_rsp_sin;
  assign RSP_SIN_NEG = r_rsp_sin_neg;
  assign RSP_ERR     = r_rsp_err;
  assign BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench for cordic_sequencer with a behavioural engine model.
module tb_cordic_sequencer;

  logic       CLK;
  logic       RESET;
  logic [1:0] REQ_VALID;
  logic [9:0] REQ_ANGLE0;
  logic [9:0] REQ_ANGLE1;
  logic [1:0] REQ_READY;
  logic [7:0] ENG_ANGLE;
  logic       ENG_RESET;
  logic [7:0] ENG_COS;
  logic [7:0] ENG_SIN;
  logic       ENG_HALT = 1'b0;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic       RSP_ID;
  logic [7:0] RSP_COS;
  logic       RSP_COS_NEG;
  logic [7:0] RSP_SIN;
  logic       RSP_SIN_NEG;
  logic       RSP_ERR;
  logic       BUSY;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_viol = 0;

  // Engine model controls
  bit halt_en    = 1'b1;
  bit stale_mode = 1'b0;
  int halt_k     = 9;
  int eng_cnt    = 0;

  cordic_sequencer #(.INIT_CYCLES(1), .TIMEOUT(31)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_ANGLE0(REQ_ANGLE0), .REQ_ANGLE1(REQ_ANGLE1),
    .REQ_READY(REQ_READY),
    .ENG_ANGLE(ENG_ANGLE), .ENG_RESET(ENG_RESET),
    .ENG_COS(ENG_COS), .ENG_SIN(ENG_SIN), .ENG_HALT(ENG_HALT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_COS(RSP_COS), .RSP_COS_NEG(RSP_COS_NEG),
    .RSP_SIN(RSP_SIN), .RSP_SIN_NEG(RSP_SIN_NEG),
    .RSP_ERR(RSP_ERR), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Engine model: HALT rises on RUN cycle halt_k and stays up until re-init.
  always @(posedge CLK) begin
    if (!ENG_RESET) begin
      eng_cnt  <= 0;
      ENG_HALT <= stale_mode;
    end else begin
      eng_cnt  <= eng_cnt + 1;
      if (stale_mode) ENG_HALT <= 1'b0;
      else            ENG_HALT <= ENG_HALT | (halt_en && (eng_cnt + 2 == halt_k));
    end
  end

  // Accept strobe must never coincide with BUSY.
  always @(negedge CLK) begin
    if (RESET && (REQ_READY != 2'b00) && BUSY) busy_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive a request and wait (bounded) for the accept strobe; ends one cycle after grant.
  task automatic grant_step(input logic [1:0] vm, input logic [9:0] a0, input logic [9:0] a1,
                            input bit hold, output int gid);
    bit found;
    found = 1'b0;
    gid = -1;
    REQ_ANGLE0 = a0;
    REQ_ANGLE1 = a1;
    REQ_VALID  = vm;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (REQ_READY != 2'b00) begin
        found = 1'b1;
        gid = REQ_READY[1] ? 1 : 0;
        break;
      end
      @(negedge CLK);
    end
    check("grant_seen", int'(found), 1);
    @(negedge CLK);
    if (!hold) REQ_VALID = 2'b00;
  endtask

  // Count cycles from grant to RSP_VALID and the ENG_RESET low cycles.
  task automatic wait_rsp(output int lat, output int low);
    bit seen;
    seen = 1'b0;
    lat = 1;
    low = 0;
    for (int i = 0; i < 64; i++) begin
      if (!ENG_RESET) low++;
      if (RSP_VALID) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
      lat++;
    end
    check("rsp_seen", int'(seen), 1);
  endtask

  // Accept the response and confirm the return to IDLE.
  task automatic handshake();
    RSP_READY = 1'b1;
    #1;
    check("ready_in_hs_cycle", int'(REQ_READY), 0);
    @(negedge CLK);
    RSP_READY = 1'b0;
    check("hs_valid_low", int'(RSP_VALID), 0);
    check("hs_err_low", int'(RSP_ERR), 0);
    check("hs_busy_low", int'(BUSY), 0);
  endtask

  typedef struct {
    logic [1:0] vm;
    logic [9:0] a0;
    logic [9:0] a1;
    int         id;
    logic [7:0] eang;
    logic [7:0] cos;
    logic       cn;
    logic [7:0] sin;
    logic       sn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int gid, lat, low;
    int exp_ids[4];

    vecs[0] = '{2'b01, 10'h020, 10'h000, 0, 8'h20, 8'd200, 1'b0, 8'd60,  1'b0};
    vecs[1] = '{2'b01, 10'h120, 10'h000, 0, 8'h20, 8'd60,  1'b1, 8'd200, 1'b0};
    vecs[2] = '{2'b01, 10'h220, 10'h000, 0, 8'h20, 8'd200, 1'b1, 8'd60,  1'b1};
    vecs[3] = '{2'b01, 10'h320, 10'h000, 0, 8'h20, 8'd60,  1'b0, 8'd200, 1'b1};
    vecs[4] = '{2'b10, 10'h000, 10'h3FF, 1, 8'hFF, 8'd60,  1'b0, 8'd200, 1'b1};
    vecs[5] = '{2'b10, 10'h120, 10'h000, 1, 8'h00, 8'd200, 1'b0, 8'd60,  1'b0};
    exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 0; exp_ids[3] = 1;

    ENG_COS    = 8'd200;
    ENG_SIN    = 8'd60;
    RESET      = 1'b0;
    REQ_VALID  = 2'b11;
    REQ_ANGLE0 = 10'h000;
    REQ_ANGLE1 = 10'h000;
    RSP_READY  = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_req_ready", int'(REQ_READY), 0);
    check("rst_eng_angle", int'(ENG_ANGLE), 0);
    check("rst_eng_reset", int'(ENG_RESET), 1);
    check("rst_rsp", int'({RSP_VALID, RSP_ID, RSP_COS, RSP_COS_NEG, RSP_SIN, RSP_SIN_NEG, RSP_ERR}), 0);
    check("rst_busy", int'(BUSY), 0);
    REQ_VALID = 2'b00;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // Table-driven jobs: quadrant sweep and single-requester grants
    for (int v = 0; v < 6; v++) begin
      grant_step(vecs[v].vm, vecs[v].a0, vecs[v].a1, 1'b0, gid);
      check($sformatf("v%0d_grant_id", v), gid, vecs[v].id);
      wait_rsp(lat, low);
      check($sformatf("v%0d_latency", v), lat, 11);
      check($sformatf("v%0d_init_low", v), low, 1);
      check($sformatf("v%0d_eng_angle", v), int'(ENG_ANGLE), int'(vecs[v].eang));
      check($sformatf("v%0d_rsp_id", v), int'(RSP_ID), vecs[v].id);
      check($sformatf("v%0d_cos", v), int'({RSP_COS_NEG, RSP_COS}), int'({vecs[v].cn, vecs[v].cos}));
      check($sformatf("v%0d_sin", v), int'({RSP_SIN_NEG, RSP_SIN}), int'({vecs[v].sn, vecs[v].sin}));
      check($sformatf("v%0d_err", v), int'(RSP_ERR), 0);
      handshake();
    end

    // Backpressure: response held, contending requests not granted
    grant_step(2'b01, 10'h220, 10'h000, 1'b0, gid);
    check("bp_grant_id", gid, 0);
    wait_rsp(lat, low);
    REQ_ANGLE1 = 10'h320;
    REQ_VALID  = 2'b11;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("bp_hold_c%0d", c),
            int'({RSP_VALID, RSP_ID, RSP_COS_NEG, RSP_COS, RSP_SIN_NEG, RSP_SIN, RSP_ERR, REQ_READY}),
            int'({1'b1, 1'b0, 1'b1, 8'd200, 1'b1, 8'd60, 1'b0, 2'b00}));
      @(negedge CLK);
    end
    handshake();
    check("bp_next_grant", int'(REQ_READY), 2);
    grant_step(2'b11, 10'h220, 10'h320, 1'b0, gid);
    check("bp_post_grant_id", gid, 1);
    wait_rsp(lat, low);
    check("bp_post_rsp", int'({RSP_ID, RSP_COS_NEG, RSP_COS, RSP_SIN_NEG, RSP_SIN}),
          int'({1'b1, 1'b0, 8'd60, 1'b1, 8'd200}));
    handshake();

    // Timeout: engine never halts
    halt_en = 1'b0;
    grant_step(2'b01, 10'h100, 10'h000, 1'b0, gid);
    wait_rsp(lat, low);
    check("to_latency", lat, 32);
    check("to_err", int'(RSP_ERR), 1);
    check("to_payload", int'({RSP_COS_NEG, RSP_COS, RSP_SIN_NEG, RSP_SIN}), 0);
    handshake();

    // Timeout with a stale HALT in the first RUN cycle only
    stale_mode = 1'b1;
    grant_step(2'b01, 10'h220, 10'h000, 1'b0, gid);
    wait_rsp(lat, low);
    check("stale_latency", lat, 32);
    check("stale_err", int'(RSP_ERR), 1);
    check("stale_payload", int'({RSP_COS_NEG, RSP_COS, RSP_SIN_NEG, RSP_SIN}), 0);
    handshake();
    stale_mode = 1'b0;

    // Async reset mid-RUN after a requester-0 grant
    grant_step(2'b01, 10'h040, 10'h000, 1'b0, gid);
    repeat (4) @(negedge CLK);
    check("ar_busy_before", int'(BUSY), 1);
    #2;
    RESET = 1'b0;
    #1;
    check("ar_busy", int'(BUSY), 0);
    check("ar_eng", int'({ENG_RESET, ENG_ANGLE}), int'({1'b1, 8'h00}));
    check("ar_rsp", int'({RSP_VALID, RSP_ID, RSP_COS, RSP_COS_NEG, RSP_SIN, RSP_SIN_NEG, RSP_ERR}), 0);
    REQ_VALID = 2'b11;
    #1;
    check("ar_req_ready", int'(REQ_READY), 0);
    @(negedge CLK);
    RESET = 1'b1;
    halt_en = 1'b1;

    // Contention after reset: grants alternate 0,1,0,1
    for (int j = 0; j < 4; j++) begin
      grant_step(2'b11, 10'h120, 10'h220, 1'b1, gid);
      check($sformatf("rr%0d_grant_id", j), gid, exp_ids[j]);
      wait_rsp(lat, low);
      check($sformatf("rr%0d_latency", j), lat, 11);
      check($sformatf("rr%0d_rsp_id", j), int'(RSP_ID), exp_ids[j]);
      if (exp_ids[j] == 0)
        check($sformatf("rr%0d_payload", j), int'({RSP_COS_NEG, RSP_COS, RSP_SIN_NEG, RSP_SIN}),
              int'({1'b1, 8'd60, 1'b0, 8'd200}));
      else
        check($sformatf("rr%0d_payload", j), int'({RSP_COS_NEG, RSP_COS, RSP_SIN_NEG, RSP_SIN}),
              int'({1'b1, 8'd200, 1'b1, 8'd60}));
      handshake();
    end
    REQ_VALID = 2'b00;
    @(negedge CLK);

    check("ready_while_busy", busy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
